seg_code_counter: RTL and testbench

- Upstream stage of the two-digit seven-segment array decoder.
- Generates the 3-bit code (B = MSB, C, D = LSB) that the decoder turns into segment patterns.
- Steps the code up or down at a prescaled rate, wraps between 0 and a programmable terminal value, and supports synchronous preload.
- A debounced-by-sync push-button toggles between stopped and running.

---
 rtl/seg_code_counter_if.sv | 34 +++
 rtl/seg_code_counter.sv | 120 ++++++++++++
 tb/tb_seg_code_counter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_code_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_code_counter_if
// Brief    : Control/status bundle between the code counter and its user:
//            button, direction, preload and range in; code bits and status
//            pulses out.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_code_counter_if;
  logic       btn;       // raw start/stop button, asynchronous to clk
  logic       up;        // 1 = increment, 0 = decrement
  logic       load;      // synchronous preload strobe
  logic [2:0] load_val;  // preload value
  logic [2:0] max;       // terminal value, range is 0..max
  logic       b;         // code bit 2 (MSB)
  logic       c;         // code bit 1
  logic       d;         // code bit 0 (LSB)
  logic       run;       // high while running
  logic       tick;      // one-cycle pulse per count step
  logic       wrap;      // one-cycle pulse on a wrapping step

  // Driver side (stimulus / upstream control)
  modport master (
    output btn, up, load, load_val, max,
    input  b, c, d, run, tick, wrap
  );

  // Counter side
  modport slave (
    input  btn, up, load, load_val, max,
    output b, c, d, run, tick, wrap
  );
endinterface
`default_nettype wire

// File: rtl/seg_code_counter.sv
`default_nettype none
// ============================================================================
// Module   : seg_code_counter
// Brief    : Prescaled 3-bit up/down code counter with programmable terminal
//            value, synchronous preload and a button-toggled run state.
//            Feeds the two-digit seven-segment array decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg_code_counter #(
  parameter int PRESCALE = 4,  // clk cycles per count step, 1..255
  parameter int PS_W     = 8   // prescaler width, 2**PS_W >= PRESCALE
) (
  input  wire                  clk,
  input  wire                  rst_n,
  seg_code_counter_if.slave    bus
);

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);

  state_t          state_q, state_d;
  logic [2:0]      btn_sync_q;           // [0],[1] synchronizer, [2] edge history
  logic [PS_W-1:0] ps_q, ps_d;
  logic [2:0]      count_q, count_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            rise;
  logic            step;

  // Button synchronizer plus one extra flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= 3'b000;
    end else begin
      btn_sync_q <= {btn_sync_q[1:0], bus.btn};
    end
  end

  assign rise = btn_sync_q[1] & ~btn_sync_q[2];

  // State, prescaler, count and status pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      ps_q    <= '0;
      count_q <= 3'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: run toggle, prescaler, preload and wrap-aware stepping
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    // Run state toggles on every button rise, independent of LOAD
    if (rise) begin
      state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
    end

    step = (state_q == RUNNING) && (ps_q == C_PS_LAST);

    if (bus.load) begin
      // Preload wins over any coincident step; the value is clamped to max
      count_d = (bus.load_val > bus.max) ? bus.max : bus.load_val;
      ps_d    = '0;
    end else begin
      if (state_q == RUNNING) begin
        ps_d = step ? '0 : ps_q + 1'b1;
        // Leaving RUNNING restarts the period from zero next time
        if (rise) begin
          ps_d = '0;
        end
      end

      if (step) begin
        tick_d = 1'b1;
        if (bus.up) begin
          if (count_q >= bus.max) begin
            count_d = 3'd0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + 3'd1;
          end
        end else begin
          // A count left above a lowered max also wraps back to max
          if ((count_q == 3'd0) || (count_q > bus.max)) begin
            count_d = bus.max;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - 3'd1;
          end
        end
      end
    end
  end

  assign bus.b    = count_q[2];
  assign bus.c    = count_q[1];
  assign bus.d    = count_q[0];
  assign bus.run  = (state_q == RUNNING);
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_code_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_code_counter
// Brief    : Self-checking bench for seg_code_counter (PRESCALE = 4):
//            preload table plus hand-written run/stop/wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_code_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  seg_code_counter_if bus ();

  seg_code_counter #(
    .PRESCALE (4),
    .PS_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] lv;
    logic [2:0] mx;
    logic [2:0] exp_cnt;
  } load_vec_t;

  load_vec_t vecs [7];

  function automatic logic [2:0] cnt();
    return {bus.b, bus.c, bus.d};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Three non-step cycles holding 'hold', then a step edge giving 'exp_c'
  task automatic step_expect(input string name, input logic [2:0] hold,
                             input logic [2:0] exp_c, input logic exp_w);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk({name, "_hold"}, 8'(cnt()), 8'(hold));
      chk({name, "_notick"}, 8'(bus.tick), 8'd0);
    end
    cyc();
    chk({name, "_cnt"}, 8'(cnt()), 8'(exp_c));
    chk({name, "_tick"}, 8'(bus.tick), 8'd1);
    chk({name, "_wrap"}, 8'(bus.wrap), 8'(exp_w));
  endtask

  initial begin
    vecs[0] = '{lv: 3'd5, mx: 3'd7, exp_cnt: 3'd5};
    vecs[1] = '{lv: 3'd6, mx: 3'd3, exp_cnt: 3'd3};
    vecs[2] = '{lv: 3'd7, mx: 3'd7, exp_cnt: 3'd7};
    vecs[3] = '{lv: 3'd2, mx: 3'd0, exp_cnt: 3'd0};
    vecs[4] = '{lv: 3'd4, mx: 3'd4, exp_cnt: 3'd4};
    vecs[5] = '{lv: 3'd1, mx: 3'd5, exp_cnt: 3'd1};
    vecs[6] = '{lv: 3'd0, mx: 3'd5, exp_cnt: 3'd0};

    bus.btn = 1'b0; bus.up = 1'b1; bus.load = 1'b0;
    bus.load_val = 3'd0; bus.max = 3'd7;

    // Reset asserted without any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt", 8'(cnt()), 8'd0);
    chk("rst_run", 8'(bus.run), 8'd0);
    chk("rst_tick", 8'(bus.tick), 8'd0);
    chk("rst_wrap", 8'(bus.wrap), 8'd0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Idle after reset: nothing moves without the button
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_cnt", 8'(cnt()), 8'd0);
      chk("idle_run", 8'(bus.run), 8'd0);
      chk("idle_tick", 8'(bus.tick), 8'd0);
    end

    // Preload table while stopped, including clamp to max
    for (int i = 0; i < 7; i++) begin
      bus.load = 1'b1; bus.load_val = vecs[i].lv; bus.max = vecs[i].mx;
      cyc();
      bus.load = 1'b0;
      chk("load_cnt", 8'(cnt()), 8'(vecs[i].exp_cnt));
      chk("load_tick", 8'(bus.tick), 8'd0);
      chk("load_wrap", 8'(bus.wrap), 8'd0);
      cyc();
      chk("load_stopped_hold", 8'(cnt()), 8'(vecs[i].exp_cnt));
      chk("load_run", 8'(bus.run), 8'd0);
    end

    // Start: button level held high; RUN follows 3 edges later
    bus.up = 1'b1; bus.max = 3'd7; bus.btn = 1'b1;
    cyc(); chk("start_run_e1", 8'(bus.run), 8'd0);
    cyc(); chk("start_run_e2", 8'(bus.run), 8'd0);
    cyc(); chk("start_run_e3", 8'(bus.run), 8'd1);

    // Count up 0..7 then wrap to 0, one step every 4 cycles
    for (int k = 1; k <= 8; k++) begin
      step_expect("up7", 3'(k - 1), 3'(k % 8), (k == 8));
    end
    chk("held_btn_still_run", 8'(bus.run), 8'd1);
    bus.btn = 1'b0;

    // Running down with max 5 after preload of 1
    bus.up = 1'b0; bus.max = 3'd5; bus.load = 1'b1; bus.load_val = 3'd1;
    cyc();
    bus.load = 1'b0;
    chk("dn_load_cnt", 8'(cnt()), 8'd1);
    chk("dn_load_tick", 8'(bus.tick), 8'd0);
    step_expect("dn_a", 3'd1, 3'd0, 1'b0);
    step_expect("dn_b", 3'd0, 3'd5, 1'b1);
    step_expect("dn_c", 3'd5, 3'd4, 1'b0);

    // LOAD on the step cycle: step discarded, value clamped
    cyc(); cyc(); cyc();
    chk("pre_coinc_cnt", 8'(cnt()), 8'd4);
    bus.load = 1'b1; bus.load_val = 3'd6; bus.max = 3'd3;
    cyc();
    bus.load = 1'b0;
    chk("coinc_cnt", 8'(cnt()), 8'd3);
    chk("coinc_tick", 8'(bus.tick), 8'd0);
    chk("coinc_wrap", 8'(bus.wrap), 8'd0);
    step_expect("coinc_next", 3'd3, 3'd2, 1'b0);

    // max = 0: every step stays at 0 with TICK and WRAP
    bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 3'd5; bus.max = 3'd0;
    cyc();
    bus.load = 1'b0;
    chk("max0_load", 8'(cnt()), 8'd0);
    step_expect("max0_a", 3'd0, 3'd0, 1'b1);
    step_expect("max0_b", 3'd0, 3'd0, 1'b1);

    // max lowered under the count, counting up
    bus.load = 1'b1; bus.load_val = 3'd6; bus.max = 3'd7;
    cyc();
    bus.load = 1'b0; bus.max = 3'd2; bus.up = 1'b1;
    chk("maxlow_up_load", 8'(cnt()), 8'd6);
    step_expect("maxlow_up", 3'd6, 3'd0, 1'b1);

    // max lowered under the count, counting down
    bus.load = 1'b1; bus.load_val = 3'd6; bus.max = 3'd7;
    cyc();
    bus.load = 1'b0; bus.max = 3'd2; bus.up = 1'b0;
    step_expect("maxlow_dn", 3'd6, 3'd2, 1'b1);

    // Stop: preload 5, press again, count frozen afterwards
    bus.load = 1'b1; bus.load_val = 3'd5; bus.max = 3'd7; bus.up = 1'b1;
    cyc();
    bus.load = 1'b0; bus.btn = 1'b1;
    cyc(); chk("stop_run_e1", 8'(bus.run), 8'd1);
    cyc(); chk("stop_run_e2", 8'(bus.run), 8'd1);
    cyc(); chk("stop_run_e3", 8'(bus.run), 8'd0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("frozen_cnt", 8'(cnt()), 8'd5);
      chk("frozen_tick", 8'(bus.tick), 8'd0);
      chk("frozen_run", 8'(bus.run), 8'd0);
    end

    // Restart, take one step, then reset asynchronously mid-period
    bus.btn = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    bus.btn = 1'b1;
    cyc(); cyc(); cyc();
    chk("restart_run", 8'(bus.run), 8'd1);
    step_expect("restart", 3'd5, 3'd6, 1'b0);
    cyc(); cyc();
    chk("pre_rst_cnt", 8'(cnt()), 8'd6);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 8'(cnt()), 8'd0);
    chk("async_rst_run", 8'(bus.run), 8'd0);
    chk("async_rst_tick", 8'(bus.tick), 8'd0);
    chk("async_rst_wrap", 8'(bus.wrap), 8'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
